// File: rtl/ram_if_pkg.sv
// ram_if_pkg: shared FSM states, march elements and Wr_Rd opcodes for the RAM BIST initiator
package ram_if_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, DONE} state_t;
  typedef enum logic [1:0] {M0, M1, M2, M3} elem_t;
  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;
endpackage

// File: rtl/bist_addr_gen.sv
// bist_addr_gen: up/down address counter with load, step and last-address flag
// ports: clk, rst (async active-low), load/load_down (reload to 0 or D-1),
//        step/down (advance in current direction), addr, last (end of sweep)
module bist_addr_gen #(
  parameter int N = 4,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         load_down,
  input  logic         step,
  input  logic         down,
  output logic [N-1:0] addr,
  output logic         last
);
  logic [N-1:0] a_q, a_d;
  always_comb a_d = load ? (load_down ? N'(D - 1) : '0) : step ? (down ? a_q - N'(1) : a_q + N'(1)) : a_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) a_q <= '0;
    else a_q <= a_d;
  assign addr = a_q;
  assign last = down ? a_q == '0 : a_q == N'(D - 1);
endmodule

// File: rtl/ram_bist_initiator.sv
// ram_bist_initiator: runs a four-element March test over a single-port RAM and reports the result
// ports: clk, rst (async active-low), start -> busy/done pulse, pass, err_count (saturating),
//        timeout (sticky), fail_addr/fail_exp/fail_got (first failure);
//        RAM side: valid, Wr_Rd, ADDR, WDATA out; RDATA, ready in
module ram_bist_initiator
  import ram_if_pkg::*;
#(
  parameter int             N       = 4,
  parameter int             D       = 16,
  parameter int             W       = 8,
  parameter logic [W-1:0]   PAT     = {W/2{2'b01}},
  parameter int             TIMEOUT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   err_count,
  output logic         timeout,
  output logic [N-1:0] fail_addr,
  output logic [W-1:0] fail_exp,
  output logic [W-1:0] fail_got,
  output logic         valid,
  output logic         Wr_Rd,
  output logic [N-1:0] ADDR,
  output logic [W-1:0] WDATA,
  input  logic [W-1:0] RDATA,
  input  logic         ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t        state_q, state_d;
  elem_t         e_q, e_d, e_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    err_q, err_d;
  logic          to_q, to_d, pass_q, pass_d;
  logic [N-1:0]  fa_q, fa_d, addr;
  logic [W-1:0]  fe_q, fe_d, fg_q, fg_d, exp_v, got;
  logic          go, tmo, acc, rd_fin, bad, adv, last, fin, nxt_el;
  assign go     = start && (state_q == IDLE || state_q == DONE);
  // the wait counter reaching TIMEOUT wins over a coincident ready
  assign tmo    = state_q == RD_WAIT && cnt_q == CW'(TIMEOUT);
  assign acc    = state_q == RD_WAIT && !tmo && ready;
  assign rd_fin = tmo || acc;
  assign exp_v  = e_q == M2 ? ~PAT : PAT;
  assign got    = acc ? RDATA : '0;
  assign bad    = tmo || (acc && RDATA != exp_v);
  // address advances after the element's last operation: the write, or the read in M3
  assign adv    = state_q == WRITE || (rd_fin && e_q == M3);
  assign fin    = adv && last && e_q == M3;
  assign nxt_el = adv && last && !fin;
  assign e_nx   = elem_t'(e_q + 2'd1);
  always_comb begin
    state_d = go ? WRITE : state_q == DONE ? IDLE : state_q == RD_REQ ? RD_WAIT :
              rd_fin && e_q != M3 ? WRITE : fin ? DONE :
              adv ? (last || e_q != M0 ? RD_REQ : WRITE) : state_q;
    e_d     = go ? M0 : nxt_el ? e_nx : e_q;
    cnt_d   = state_q == RD_WAIT && !rd_fin ? CW'(cnt_q + 1'b1) : '0;
    err_d   = go ? 8'd0 : bad && err_q != 8'hFF ? 8'(err_q + 1'b1) : err_q;
    to_d    = !go && (to_q || tmo);
    fa_d    = go ? '0 : bad && err_q == 8'd0 ? addr : fa_q;
    fe_d    = go ? '0 : bad && err_q == 8'd0 ? exp_v : fe_q;
    fg_d    = go ? '0 : bad && err_q == 8'd0 ? got : fg_q;
    pass_d  = go ? 1'b0 : fin ? err_d == 8'd0 : pass_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      e_q     <= M0;
      cnt_q   <= '0;
      err_q   <= '0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
      fa_q    <= '0;
      fe_q    <= '0;
      fg_q    <= '0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
      fa_q    <= fa_d;
      fe_q    <= fe_d;
      fg_q    <= fg_d;
    end
  bist_addr_gen #(.N(N), .D(D)) u_addr (
    .clk       (clk),
    .rst       (rst),
    .load      (go || nxt_el),
    .load_down (!go && e_nx == M2),
    .step      (adv && !last),
    .down      (e_q == M2),
    .addr      (addr),
    .last      (last)
  );
  assign busy      = state_q == WRITE || state_q == RD_REQ || state_q == RD_WAIT;
  assign done      = state_q == DONE;
  assign valid     = state_q == WRITE || state_q == RD_REQ;
  assign Wr_Rd     = state_q == WRITE ? WR : RD;
  assign ADDR      = valid ? addr : '0;
  assign WDATA     = state_q == WRITE ? (e_q == M1 ? ~PAT : PAT) : '0;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign timeout   = to_q;
  assign fail_addr = fa_q;
  assign fail_exp  = fe_q;
  assign fail_got  = fg_q;
endmodule

// File: tb/tb_ram_bist_initiator.sv
// tb_ram_bist_initiator: faulty-RAM model plus March reference model checking the BIST initiator
module tb_ram_bist_initiator;
  localparam int D = 16, TO = 4, NRD = 48;
  localparam logic [7:0] PAT = 8'h55;
  logic clk = 0, rst = 0, start = 0, ready = 0;
  logic [7:0] RDATA = 0;
  logic busy, done, pass, timeout, valid, Wr_Rd;
  logic [7:0] err_count, fail_exp, fail_got, WDATA;
  logic [3:0] fail_addr, ADDR;
  ram_bist_initiator dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .timeout(timeout), .fail_addr(fail_addr), .fail_exp(fail_exp),
    .fail_got(fail_got), .valid(valid), .Wr_Rd(Wr_Rd), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .ready(ready)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [D];
  logic [7:0] sm [D];
  logic [7:0] sv [D];
  int dly [NRD];
  logic [12:0] req_q [$];
  logic [12:0] exp_req [$];
  int ri = 0, viol = 0, nvec = 0, nerr = 0;
  int exp_done;
  logic [7:0] exp_err, exp_fe, exp_fg;
  logic [3:0] exp_fa;
  logic exp_to;
  initial begin : ram_model
    logic pend = 0;
    int wcnt = 0;
    logic [3:0] raddr = 0;
    forever begin
      @(negedge clk);
      ready = 0;
      RDATA = 8'($urandom);
      if (!rst) pend = 0;
      if (!valid && {Wr_Rd, ADDR, WDATA} !== 13'd0) viol++;
      if (valid && Wr_Rd) mem[ADDR] = WDATA;
      if (pend) begin
        if (wcnt == 0) begin
          ready = 1;
          RDATA = (mem[raddr] & ~sm[raddr]) | (sv[raddr] & sm[raddr]);
          pend = 0;
        end else wcnt--;
      end
      if (valid) req_q.push_back({Wr_Rd, ADDR, Wr_Rd ? WDATA : 8'h00});
      if (valid && !Wr_Rd) begin
        pend = 1;
        raddr = ADDR;
        wcnt = ri < NRD ? dly[ri] : 0;
        ri++;
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model();
    logic [7:0] m [D];
    logic [7:0] ex, g;
    logic [3:0] a;
    int r = 0;
    bit t;
    exp_req.delete();
    exp_done = 1;
    exp_err = 0;
    exp_to = 0;
    exp_fa = 0;
    exp_fe = 0;
    exp_fg = 0;
    for (int el = 0; el < 4; el++)
      for (int i = 0; i < D; i++) begin
        a = 4'(el == 2 ? D - 1 - i : i);
        if (el > 0) begin
          ex = el == 2 ? ~PAT : PAT;
          t = dly[r] >= TO;
          g = t ? 8'h00 : (m[a] & ~sm[a]) | (sv[a] & sm[a]);
          exp_req.push_back({1'b0, a, 8'h00});
          exp_done += 2 + (t ? TO : dly[r]);
          exp_to = exp_to | t;
          if (t || g != ex) begin
            if (exp_err == 0) begin
              exp_fa = a;
              exp_fe = ex;
              exp_fg = g;
            end
            if (exp_err != 255) exp_err++;
          end
          r++;
        end
        if (el < 3) begin
          m[a] = el == 1 ? ~PAT : PAT;
          exp_req.push_back({1'b1, a, m[a]});
          exp_done++;
        end
      end
  endtask
  task automatic run(input int pulse_at);
    int cyc, nmis;
    model();
    ri = 0;
    viol = 0;
    req_q.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 1;
    chk("busy_c1", busy, 1);
    chk("status_cleared", {pass, timeout, err_count, fail_addr, fail_exp, fail_got}, 0);
    while (done !== 1'b1 && cyc < 2000) begin
      start = cyc == pulse_at;
      @(negedge clk);
      cyc++;
    end
    start = 0;
    chk("done_cycle", cyc, exp_done);
    chk("busy_at_done", busy, 0);
    chk("pass", pass, exp_err == 0);
    chk("err_count", err_count, exp_err);
    chk("timeout", timeout, exp_to);
    chk("fail_info", {fail_addr, fail_exp, fail_got}, {exp_fa, exp_fe, exp_fg});
    chk("req_count", req_q.size(), exp_req.size());
    nmis = 0;
    for (int i = 0; i < exp_req.size() && i < req_q.size(); i++)
      if (req_q[i] !== exp_req[i]) nmis++;
    chk("req_seq_mismatches", nmis, 0);
    chk("ram_side_zero_when_idle", viol, 0);
  endtask
  task automatic settle();
    logic p;
    p = pass;
    @(negedge clk);
    chk("done_pulse_one_cycle", {done, busy}, 0);
    chk("pass_hold", pass, p);
  endtask
  task automatic clear_faults();
    for (int i = 0; i < D; i++) begin
      sm[i] = 0;
      sv[i] = 0;
    end
    for (int i = 0; i < NRD; i++) dly[i] = 0;
  endtask
  initial begin
    int fa, nf;
    logic [7:0] b;
    clear_faults();
    for (int i = 0; i < D; i++) mem[i] = 0;
    #12;
    chk("reset_outputs", {busy, done, pass, err_count, timeout, fail_addr, fail_exp, fail_got,
                          valid, Wr_Rd, ADDR, WDATA}, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    run(0);
    settle();
    sm[5] = 8'h01;
    sv[5] = 8'h01;
    run(0);
    settle();
    clear_faults();
    for (int i = 0; i < D; i++) sm[i] = 8'hFF;
    run(0);
    settle();
    clear_faults();
    dly[3] = 5;
    run(0);
    dly[3] = 0;
    run(50);
    settle();
    repeat (6) begin
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int f = 0; f < nf; f++) begin
        fa = $urandom_range(0, D - 1);
        b = 8'(1 << $urandom_range(0, 7));
        sm[fa] = sm[fa] | b;
        sv[fa] = $urandom_range(0, 1) != 0 ? (sv[fa] | b) : (sv[fa] & ~b);
      end
      for (int i = 0; i < NRD; i++)
        dly[i] = $urandom_range(0, 9) < 7 ? 0 : $urandom_range(1, 5);
      run(0);
      settle();
    end
    clear_faults();
    for (int i = 0; i < D; i++) sm[i] = 8'hFF;
    ri = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (29) @(negedge clk);
    chk("pre_reset_err_count", err_count, 4);
    #1 rst = 0;
    #1;
    chk("reset_async_clear", {busy, done, pass, err_count, timeout, fail_addr, fail_exp, fail_got,
                              valid, Wr_Rd, ADDR, WDATA}, 0);
    @(negedge clk);
    rst = 1;
    req_q.delete();
    repeat (10) @(negedge clk);
    chk("no_req_after_reset", req_q.size(), 0);
    chk("idle_after_reset", {busy, done}, 0);
    clear_faults();
    run(0);
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ram_bist_initiator.md
# ram_bist_initiator

Built-in self-test initiator that drives the single-port RAM request interface (valid / Wr_Rd / ADDR / WDATA in, RDATA / ready back) from the requester side. On a start pulse it runs a fixed four-element March sequence over every address, issuing writes and reads and comparing each returned word. It reports pass/fail, the first failing address with its expected and received data, a saturating error count, and a sticky read-timeout flag. It sits between the system test controller and one RAM instance, muxed ahead of the functional requester.

## Interface

Parameters:
- N, 4, RAM address width
- D, 16, RAM depth; addresses 0..D-1 are tested
- W, 8, RAM data width
- PAT, {W/2{2'b01}} (0x55 for W=8), background pattern; ~PAT is its inverse
- TIMEOUT, 4, maximum RD_WAIT cycles without ready before a read is declared failed

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin test; sampled only in IDLE or DONE
- busy  out  1  test sequence in progress
- done  out  1  one-cycle pulse at completion
- pass  out  1  valid after done: 1 when err_count==0
- err_count  out  8  number of failed reads, saturates at 255
- timeout  out  1  sticky: at least one read timed out
- fail_addr  out  N  address of first failure
- fail_exp  out  W  expected data at first failure
- fail_got  out  W  RDATA at first failure; 0 if that failure was a timeout
- valid  out  1  RAM request valid
- Wr_Rd  out  1  1 = write, 0 = read
- ADDR  out  N  RAM address
- WDATA  out  W  RAM write data
- RDATA  in  W  RAM read data
- ready  in  1  RAM read-data-valid

## Operation

- States: IDLE, WRITE, RD_REQ, RD_WAIT, DONE. Element counter e in 0..3; address counter a.
- March elements:
  - M0: ascending, w(PAT)
  - M1: ascending, r(PAT) then w(~PAT)
  - M2: descending from D-1, r(~PAT) then w(PAT)
  - M3: ascending, r(PAT)
- Write: WRITE drives valid=1, Wr_Rd=1, ADDR=a, WDATA=pattern for exactly one cycle.
- Read: RD_REQ drives valid=1, Wr_Rd=0, ADDR=a for one cycle. RD_WAIT drives valid=0 and waits for ready=1, then compares RDATA to the expected value.
- In M1 and M2 the write follows the read at the same address. The address advances after the element's last operation. After the last address of an element, e increments and a reloads (0, or D-1 for M2).
- Mismatch or timeout:
  - err_count increments, saturating at 255.
  - On the first error of a run only, fail_addr, fail_exp and fail_got are captured.
  - The sequence always continues; there is no abort.
- Timeout: RD_WAIT count reaches TIMEOUT with no ready. Sets timeout, counts as an error with got=0, and proceeds to the next operation.
- Start:
  - start in IDLE or DONE clears err_count, timeout, fail_* and pass, then enters WRITE with e=0, a=0.
  - start while busy is ignored.
- Reset values: all outputs 0, state IDLE. Reset mid-run aborts asynchronously: valid drops immediately, all status clears.
- When valid=0, RAM-side outputs ADDR, WDATA and Wr_Rd are driven 0.

## Timing

- Cycle 0: start high in IDLE. busy=1 from cycle 1.
- With ready returned on the first RD_WAIT cycle:
  - M0 occupies cycles 1..D.
  - M1 occupies D+1..4D (3 cycles per address).
  - M2 occupies 4D+1..7D.
  - M3 occupies 7D+1..9D (2 cycles per address).
- Cycle 9D+1: state DONE, done=1, busy=0, pass valid. For D=16 this is cycle 145.
- Each ready stall adds one cycle. A timeout adds TIMEOUT cycles.
- DONE lasts one cycle, then IDLE. pass and fail_* hold until the next start or reset.
- RDATA is sampled only on a cycle with ready=1 in RD_WAIT. ready seen in any other state is ignored.

## Structure

- Shared package ram_if_pkg holds:
  - state enum
  - march-element enum (M0..M3)
  - RD/WR opcode constants for Wr_Rd (WR=1, RD=0)
- One sub-module, bist_addr_gen: up/down address counter with load, step and last-address flag, parameterised by N and D.

## Test plan

- Fault-free RAM model (ready one cycle after a read request), start pulse -> done at cycle 145, pass=1, err_count=0, timeout=0; M0 issues 16 writes of 0x55 to addresses 0..15.
- Addr 5 bit 0 stuck-at-1 -> M2 read at addr 5 expects 0xAA, gets 0xAB -> fail_addr=5, fail_exp=0xAA, fail_got=0xAB, err_count=1, pass=0.
- Model returns 0x00 on every read -> err_count=48, first failure fail_addr=0, fail_exp=0x55, fail_got=0x00.
- ready withheld for the M1 read of addr 3 -> RD_WAIT lasts 4 cycles, then timeout=1, err_count=1, fail_got=0; done at cycle 149.
- start pulsed at cycle 50 (busy) -> ignored, done still at 145; start in DONE -> status cleared, new run completes.
- rst low at cycle 30 -> valid, busy and all status go 0 immediately; after release, state is IDLE and no RAM request is issued without a new start.
